// File: rtl/pipe_ctrl_unit_if.sv
// Bundle of signals between the ID/EX datapath and the pipeline control unit.
//
// Handshake semantics: there is no valid/ready pair here. id_valid only
// qualifies the ID-stage fields in the same cycle. Back-pressure to the
// front end is carried solely by ifid_stall (hold PC and IF/ID) and
// ifid_flush (load a bubble into IF/ID). The two are never 1 together.
interface pipe_ctrl_unit_if #(
    parameter int REG_ADDR_W = 5
) ();
    // ID-stage instruction fields and EX-stage redirect
    logic                  id_valid;
    logic [6:0]            id_opcode;
    logic [6:0]            id_funct7;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  ex_branch_taken;

    // Hazard controls and staged control bundles
    logic                  ifid_stall;
    logic                  ifid_flush;
    logic [12:0]           ex_ctrl;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [12:0]           mem_ctrl;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [12:0]           wb_ctrl;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  muldiv_busy;

    // Datapath side: supplies instruction fields, consumes controls
    modport master (
        output id_valid, id_opcode, id_funct7, id_rs1, id_rs2, id_rd,
        output ex_branch_taken,
        input  ifid_stall, ifid_flush,
        input  ex_ctrl, ex_rd, mem_ctrl, mem_rd, wb_ctrl, wb_rd,
        input  muldiv_busy
    );

    // Control unit side
    modport slave (
        input  id_valid, id_opcode, id_funct7, id_rs1, id_rs2, id_rd,
        input  ex_branch_taken,
        output ifid_stall, ifid_flush,
        output ex_ctrl, ex_rd, mem_ctrl, mem_rd, wb_ctrl, wb_rd,
        output muldiv_busy
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the ID instruction into a 13-bit control
// bundle, carries it through ID/EX, EX/MEM and MEM/WB, and produces the
// load-use stall, branch flush and multi-cycle mul/div hold for the datapath.
//
// Bundle layout (MSB..LSB):
//   {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp[1:0],
//    Branch, JalrSel, RWSel[1:0], MulDiv, Valid}
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    pipe_ctrl_unit_if.slave  ctrl_if,
    output logic [CNT_W-1:0] dbg_cnt_o
);

    // Bit positions inside the control bundle
    localparam int B_ALUSRC   = 12;
    localparam int B_MEMTOREG = 11;
    localparam int B_REGWRITE = 10;
    localparam int B_MEMREAD  = 9;
    localparam int B_MEMWRITE = 8;
    localparam int B_ALUOP1   = 7;
    localparam int B_ALUOP0   = 6;
    localparam int B_BRANCH   = 5;
    localparam int B_JALRSEL  = 4;
    localparam int B_RWSEL1   = 3;
    localparam int B_RWSEL0   = 2;
    localparam int B_MULDIV   = 1;
    localparam int B_VALID    = 0;

    // RV32 major opcodes recognised by the decoder
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Value loaded into the hold counter when a mul/div enters EX; zero
    // for MULDIV_LAT=1 so a single-cycle unit never holds the pipe.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

    localparam logic [12:0]           BUBBLE_CTRL = '0;
    localparam logic [REG_ADDR_W-1:0] BUBBLE_RD   = '0;

    // Pipeline registers and their next-state values
    logic [12:0]           ex_ctrl_q,  ex_ctrl_d;
    logic [REG_ADDR_W-1:0] ex_rd_q,    ex_rd_d;
    logic [12:0]           mem_ctrl_q, mem_ctrl_d;
    logic [REG_ADDR_W-1:0] mem_rd_q,   mem_rd_d;
    logic [12:0]           wb_ctrl_q,  wb_ctrl_d;
    logic [REG_ADDR_W-1:0] wb_rd_q,    wb_rd_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;

    // Opcode class flags
    logic is_r, is_lw, is_sw, is_i, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic known_op;
    logic uses_rs1, uses_rs2;

    // ID-stage decode results and hazard terms
    logic [12:0]           dec_ctrl;
    logic [REG_ADDR_W-1:0] dec_rd;
    logic                  load_use;
    logic                  busy;
    logic                  flush;
    logic                  stall;

    assign is_r     = (ctrl_if.id_opcode == OP_R);
    assign is_lw    = (ctrl_if.id_opcode == OP_LW);
    assign is_sw    = (ctrl_if.id_opcode == OP_SW);
    assign is_i     = (ctrl_if.id_opcode == OP_I);
    assign is_br    = (ctrl_if.id_opcode == OP_BR);
    assign is_jal   = (ctrl_if.id_opcode == OP_JAL);
    assign is_jalr  = (ctrl_if.id_opcode == OP_JALR);
    assign is_lui   = (ctrl_if.id_opcode == OP_LUI);
    assign is_auipc = (ctrl_if.id_opcode == OP_AUIPC);

    assign known_op = is_r | is_lw | is_sw | is_i | is_br | is_jal |
                      is_jalr | is_lui | is_auipc;

    assign uses_rs1 = is_r | is_lw | is_sw | is_i | is_br | is_jalr;
    assign uses_rs2 = is_r | is_sw | is_br;

    // Main decoder: an unknown opcode or an empty IF/ID slot gives an
    // all-zero bundle, so it travels down the pipe exactly like a bubble.
    always_comb begin
        dec_ctrl = '0;
        dec_rd   = '0;
        if (ctrl_if.id_valid && known_op) begin
            dec_ctrl[B_ALUSRC]   = is_lw | is_sw | is_i | is_jalr;
            dec_ctrl[B_MEMTOREG] = is_lw;
            dec_ctrl[B_REGWRITE] = is_r | is_lw | is_i | is_jal | is_jalr |
                                   is_lui | is_auipc;
            dec_ctrl[B_MEMREAD]  = is_lw;
            dec_ctrl[B_MEMWRITE] = is_sw;
            dec_ctrl[B_ALUOP1]   = is_r | is_jal | is_lui | is_i;
            dec_ctrl[B_ALUOP0]   = is_br | is_jal | is_lui;
            dec_ctrl[B_BRANCH]   = is_br | is_jal;
            dec_ctrl[B_JALRSEL]  = is_jalr;
            dec_ctrl[B_RWSEL1]   = is_lui | is_auipc;
            dec_ctrl[B_RWSEL0]   = is_jal | is_jalr | is_auipc;
            dec_ctrl[B_MULDIV]   = is_r & (ctrl_if.id_funct7 == F7_MULDIV);
            dec_ctrl[B_VALID]    = 1'b1;
            dec_rd               = ctrl_if.id_rd;
        end
    end

    // Hazard detection: a load in EX whose destination feeds a source
    // actually read by the ID instruction; x0 never creates a dependency.
    always_comb begin
        load_use = 1'b0;
        if (ex_ctrl_q[B_MEMREAD] && (ex_rd_q != '0) && ctrl_if.id_valid) begin
            load_use = (uses_rs1 && (ex_rd_q == ctrl_if.id_rs1)) ||
                       (uses_rs2 && (ex_rd_q == ctrl_if.id_rs2));
        end
    end

    assign busy  = (cnt_q != '0);
    // A held mul/div keeps the redirecting instruction out of EX, so a
    // redirect can only be acted on once the hold is over.
    assign flush = ctrl_if.ex_branch_taken & ~busy;
    assign stall = (busy | load_use) & ~flush;

    // Next-state selection for all pipeline registers, highest priority
    // first: mul/div hold, redirect, load-use, normal advance.
    always_comb begin
        ex_ctrl_d  = ex_ctrl_q;
        ex_rd_d    = ex_rd_q;
        mem_ctrl_d = ex_ctrl_q;
        mem_rd_d   = ex_rd_q;
        wb_ctrl_d  = mem_ctrl_q;
        wb_rd_d    = mem_rd_q;
        cnt_d      = cnt_q;
        if (busy) begin
            // EX keeps the mul/div; a bubble drains into MEM behind it
            mem_ctrl_d = BUBBLE_CTRL;
            mem_rd_d   = BUBBLE_RD;
            cnt_d      = cnt_q - 1'b1;
        end else if (flush || load_use) begin
            ex_ctrl_d = BUBBLE_CTRL;
            ex_rd_d   = BUBBLE_RD;
        end else begin
            ex_ctrl_d = dec_ctrl;
            ex_rd_d   = dec_rd;
            if (dec_ctrl[B_MULDIV]) begin
                cnt_d = CNT_LOAD;
            end
        end
    end

    // Pipeline registers and hold counter; async reset empties the pipe
    // and aborts any mul/div in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_ctrl_q  <= '0;
            ex_rd_q    <= '0;
            mem_ctrl_q <= '0;
            mem_rd_q   <= '0;
            wb_ctrl_q  <= '0;
            wb_rd_q    <= '0;
            cnt_q      <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rd_q    <= ex_rd_d;
            mem_ctrl_q <= mem_ctrl_d;
            mem_rd_q   <= mem_rd_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_rd_q    <= wb_rd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ctrl_if.ifid_stall  = stall;
    assign ctrl_if.ifid_flush  = flush;
    assign ctrl_if.ex_ctrl     = ex_ctrl_q;
    assign ctrl_if.ex_rd       = ex_rd_q;
    assign ctrl_if.mem_ctrl    = mem_ctrl_q;
    assign ctrl_if.mem_rd      = mem_rd_q;
    assign ctrl_if.wb_ctrl     = wb_ctrl_q;
    assign ctrl_if.wb_rd       = wb_rd_q;
    assign ctrl_if.muldiv_busy = busy;
    assign dbg_cnt_o           = cnt_q;

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the single-cycle main decoder.
- Decodes the 7-bit opcode in ID, plus funct7 for the RV32M mul/div class.
- Carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Generates load-use stall, branch/jump flush and a parametrised multi-cycle mul/div hold, so the datapath's pipeline registers only need stall/flush enables.

Parameters:
- REG_ADDR_W, 5: register-index width.
- MULDIV_LAT, 4: EX-stage occupancy in cycles for a mul/div instruction; must be ≥1.
- CNT_W, 3: width of the mul/div counter; must satisfy 2^CNT_W > MULDIV_LAT.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode  in  7  opcode of the ID instruction.
- id_funct7  in  7  funct7 of the ID instruction.
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register indices of the ID instruction.
- ex_branch_taken  in  1  EX-resolved redirect (taken branch, JAL or JALR).
- ifid_stall  out  1  hold PC and IF/ID.
- ifid_flush  out  1  load bubble into IF/ID.
- ex_ctrl  out  13  registered ID/EX bundle {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp[1:0], Branch, JalrSel, RWSel[1:0], MulDiv, Valid}.
- ex_rd  out  REG_ADDR_W  registered destination index in EX.
- mem_ctrl  out  13  EX/MEM copy of the bundle.
- mem_rd  out  REG_ADDR_W  EX/MEM copy of the destination index.
- wb_ctrl  out  13  MEM/WB copy of the bundle.
- wb_rd  out  REG_ADDR_W  MEM/WB copy of the destination index.
- muldiv_busy  out  1  mul/div occupying EX with more cycles remaining.

Behaviour:
- Decode, combinational in ID, opcodes R=0110011, LW=0000011, SW=0100011, I=0010011, BR=1100011, JAL=1101111, JALR=1100111, LUI=0110111, AUIPC=0010111:
  - ALUSrc = LW|SW|I|JALR.
  - MemtoReg = MemRead = LW.
  - RegWrite = R|LW|I|JAL|JALR|LUI|AUIPC.
  - MemWrite = SW.
  - ALUOp[0] = BR|JAL|LUI.
  - ALUOp[1] = R|JAL|LUI|I.
  - Branch = BR|JAL.
  - JalrSel = JALR.
  - RWSel[0] = JAL|JALR|AUIPC.
  - RWSel[1] = LUI|AUIPC.
  - MulDiv = R & funct7==0000001.
  - Valid = id_valid & opcode is one of the nine above.
  - Unknown opcode or id_valid=0 gives an all-zero bundle.
- Register usage:
  - uses_rs1 = R|LW|SW|I|BR|JALR.
  - uses_rs2 = R|SW|BR.
- load_use = ex_ctrl.MemRead & ex_rd≠0 & id_valid & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
- Mul/div counter `cnt`:
  - Loads MULDIV_LAT-1 on the edge that a MulDiv bundle enters ID/EX.
  - Decrements while nonzero.
  - muldiv_busy = (cnt≠0).
  - MULDIV_LAT=1 means no hold.
- Per-edge priority, highest first:
  1. reset low: all pipeline registers and cnt cleared asynchronously. Every output is 0, except ifid_stall, ifid_flush and muldiv_busy, which follow combinationally from the cleared state and are 0.
  2. muldiv_busy: ID/EX holds; EX/MEM loads a bubble; MEM/WB advances; ifid_stall=1. ex_branch_taken is ignored.
  3. ex_branch_taken: ifid_flush=1; ID/EX loads a bubble; EX/MEM and MEM/WB advance.
  4. load_use: ifid_stall=1; ID/EX loads a bubble; later stages advance.
  5. Otherwise all three registers advance.
- A bubble is an all-zero bundle with rd=0.
- ifid_stall and ifid_flush are combinational and never both 1; flush wins.
- EX/MEM and MEM/WB always advance, apart from the mul/div bubble.
- Latency: a bundle decoded in ID appears on ex_ctrl one cycle later, mem_ctrl two cycles later and wb_ctrl three cycles later. Add MULDIV_LAT-1 extra cycles for mul/div.
- Reset asserted mid-hold aborts the mul/div. After release, cnt=0 and the pipeline is empty.

Test Plan:
- Reset low, then release; feed ADDI (0010011, rd=5) with id_valid=1 → next cycle ex_ctrl has ALUSrc=1, RegWrite=1, ALUOp=10, Valid=1, ex_rd=5; mem_ctrl matches one cycle later and wb_ctrl two cycles later. Before release every output is 0.
- LW rd=3, then ADD rs1=3 → one cycle with ifid_stall=1 and an ID/EX bubble (ex_ctrl=0); ADD enters EX on the following cycle. LW rd=0 then ADD rs1=0 → no stall.
- BEQ in EX with ex_branch_taken=1 → ifid_flush=1, ifid_stall=0, and the next ex_ctrl is a bubble. Repeat with load_use also true → flush wins.
- MUL (funct7=0000001) with MULDIV_LAT=4 → muldiv_busy high for 3 cycles, ifid_stall=1 throughout, mem_ctrl=0 for those 3 cycles, then the MUL bundle reaches mem_ctrl with MulDiv=1. With MULDIV_LAT=1 → no stall.
- Assert reset low during the second busy cycle → ex/mem/wb outputs and muldiv_busy are 0 immediately (asynchronous). After release, a new ADD flows with 1-cycle latency.
- Opcode 1111111 with id_valid=1 → the ex_ctrl bundle is all zero, including Valid=0.
